// File: rtl/branch_pkg.sv
// Shared definitions for the PC / branch-resolution unit.
package branch_pkg;

    // Branch mode as carried on branch_ctl.
    typedef enum logic [2:0] {
        BR_NOP = 3'b000,
        BR_BR  = 3'b001,
        BR_B   = 3'b010,
        BR_BL  = 3'b011,
        BR_BZ  = 3'b100,
        BR_BNZ = 3'b101,
        BR_BCY = 3'b110,
        BR_RET = 3'b111
    } br_ctl_e;

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer. A push while
// full overwrites the oldest entry; a pop while empty changes nothing.
module ras_stack
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            push_data,
    output logic [W-1:0]            pop_data,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    ovf_evt,
    output logic                    udf_evt
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] top;
    logic [PW-1:0] top_inc;
    logic [PW-1:0] top_dec;
    logic          full;
    logic          empty;

    // Pointer neighbours with explicit wrap so non-power-of-two depths work.
    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        top_inc  = (top == PW'(DEPTH - 1)) ? '0 : top + PW'(1);
        top_dec  = (top == '0) ? PW'(DEPTH - 1) : top - PW'(1);
        pop_data = mem[top];
        ovf_evt  = push & full;
        udf_evt  = pop & empty;
    end

    // Top pointer and occupancy; a full push advances but keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top <= top_inc;
            if (!full) count <= count + CW'(1);
        end else if (pop && !empty) begin
            top   <= top_dec;
            count <= count - CW'(1);
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) mem[top_inc] <= push_data;
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Registered fetch PC with single-cycle branch resolution, RAS for calls
// and returns, stall hold and sticky RAS error flags.
module pc_branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned      PC_W      = 32,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter int unsigned      PC_INC    = 1,
    parameter logic [PC_W-1:0]  RESET_PC  = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        branch_valid,
    input  logic [2:0]                  branch_ctl,
    input  logic [PC_W-1:0]             branch_imm_in1,
    input  logic [PC_W-1:0]             branch_imm_in2,
    input  logic [PC_W-1:0]             branch_reg_in,
    input  logic                        flag_zero,
    input  logic                        flag_carry,
    input  logic                        clr_err,
    output logic [PC_W-1:0]             pc_out,
    output logic                        branch_taken,
    output logic [cnt_w(RAS_DEPTH)-1:0] ras_count,
    output logic                        ras_ovf,
    output logic                        ras_udf
);

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] pop_data;
    logic            next_taken;
    logic            push;
    logic            pop;
    logic            ovf_evt;
    logic            udf_evt;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (seq),
        .pop_data  (pop_data),
        .count     (ras_count),
        .ovf_evt   (ovf_evt),
        .udf_evt   (udf_evt)
    );

    // Target selection and RAS requests; stall suppresses all RAS action.
    always_comb begin
        seq        = pc_out + PC_W'(PC_INC);
        next_pc    = seq;
        next_taken = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (branch_valid && !stall) begin
            case (br_ctl_e'(branch_ctl))
                BR_NOP: ;
                BR_BR: begin
                    next_pc    = branch_reg_in;
                    next_taken = 1'b1;
                end
                BR_B: begin
                    next_pc    = pc_out + branch_imm_in1;
                    next_taken = 1'b1;
                end
                BR_BL: begin
                    next_pc    = pc_out + branch_imm_in1;
                    next_taken = 1'b1;
                    push       = 1'b1;
                end
                BR_BZ: if (flag_zero) begin
                    next_pc    = pc_out + branch_imm_in2;
                    next_taken = 1'b1;
                end
                BR_BNZ: if (!flag_zero) begin
                    next_pc    = pc_out + branch_imm_in2;
                    next_taken = 1'b1;
                end
                BR_BCY: if (flag_carry) begin
                    next_pc    = pc_out + branch_imm_in2;
                    next_taken = 1'b1;
                end
                BR_RET: begin
                    pop = 1'b1;
                    if (ras_count != '0) begin
                        next_pc    = pop_data;
                        next_taken = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC and taken pulse; stall holds the PC and drops the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out       <= RESET_PC;
            branch_taken <= 1'b0;
        end else if (stall) begin
            branch_taken <= 1'b0;
        end else begin
            pc_out       <= next_pc;
            branch_taken <= next_taken;
        end
    end

    // Sticky error flags; a new event outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ovf <= 1'b0;
            ras_udf <= 1'b0;
        end else begin
            ras_ovf <= ovf_evt | (ras_ovf & ~clr_err);
            ras_udf <= udf_evt | (ras_udf & ~clr_err);
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_branch_unit;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [2:0]  branch_ctl = '0;
    logic [31:0] imm1 = '0;
    logic [31:0] imm2 = '0;
    logic [31:0] regv = '0;
    logic        flag_zero = 1'b0;
    logic        flag_carry = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] pc_out;
    logic        branch_taken;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_udf;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    pc_branch_unit #(
        .PC_W      (PC_W),
        .RAS_DEPTH (DEPTH),
        .PC_INC    (1),
        .RESET_PC  (32'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_valid   (branch_valid),
        .branch_ctl     (branch_ctl),
        .branch_imm_in1 (imm1),
        .branch_imm_in2 (imm2),
        .branch_reg_in  (regv),
        .flag_zero      (flag_zero),
        .flag_carry     (flag_carry),
        .clr_err        (clr_err),
        .pc_out         (pc_out),
        .branch_taken   (branch_taken),
        .ras_count      (ras_count),
        .ras_ovf        (ras_ovf),
        .ras_udf        (ras_udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: return addresses in a queue, newest at the back.
    logic [31:0] m_pc;
    bit          m_taken, m_ovf, m_udf;
    logic [31:0] m_ras[$];
    logic [31:0] m_seq, m_nt;
    bit          m_tk, m_no, m_nu;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'd0; m_taken = 0; m_ovf = 0; m_udf = 0;
            m_ras.delete();
        end else if (stall) begin
            m_taken = 0;
            if (clr_err) begin m_ovf = 0; m_udf = 0; end
        end else begin
            m_seq = m_pc + 32'd1;
            m_nt = m_seq; m_tk = 0; m_no = 0; m_nu = 0;
            if (branch_valid) begin
                case (branch_ctl)
                    3'd1: begin m_nt = regv; m_tk = 1; end
                    3'd2: begin m_nt = m_pc + imm1; m_tk = 1; end
                    3'd3: begin
                        m_nt = m_pc + imm1; m_tk = 1;
                        if (m_ras.size() == DEPTH) begin
                            void'(m_ras.pop_front());
                            m_no = 1;
                        end
                        m_ras.push_back(m_seq);
                    end
                    3'd4: if (flag_zero)  begin m_nt = m_pc + imm2; m_tk = 1; end
                    3'd5: if (!flag_zero) begin m_nt = m_pc + imm2; m_tk = 1; end
                    3'd6: if (flag_carry) begin m_nt = m_pc + imm2; m_tk = 1; end
                    3'd7: begin
                        if (m_ras.size() == 0) m_nu = 1;
                        else begin m_nt = m_ras.pop_back(); m_tk = 1; end
                    end
                    default: ;
                endcase
            end
            m_ovf   = m_no | (m_ovf & !clr_err);
            m_udf   = m_nu | (m_udf & !clr_err);
            m_pc    = m_nt;
            m_taken = m_tk;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("pc", pc_out, m_pc);
            check("taken", 32'(branch_taken), 32'(m_taken));
            check("count", 32'(ras_count), 32'(m_ras.size()));
            check("ovf", 32'(ras_ovf), 32'(m_ovf));
            check("udf", 32'(ras_udf), 32'(m_udf));
        end
    end

    task automatic cyc(input bit v, input logic [2:0] c, input logic [31:0] i1,
                       input logic [31:0] i2, input logic [31:0] r, input bit z,
                       input bit cy, input bit st, input bit clr);
        branch_valid = v; branch_ctl = c; imm1 = i1; imm2 = i2; regv = r;
        flag_zero = z; flag_carry = cy; stall = st; clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_to(input int n);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < n; i++) idle();
    endtask

    initial begin
        // Reset and sequential fetch
        #12 rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_pc", pc_out, 32'd0);
        check("rst_taken", 32'(branch_taken), 32'd0);
        check("rst_count", 32'(ras_count), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            idle();
            check("seq_pc", pc_out, 32'(i));
        end
        check("model_pc", m_pc, 32'd3);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("async_pc", pc_out, 32'd0);
        check("async_taken", 32'(branch_taken), 32'd0);
        #1 rst_n = 1'b1;

        // Unconditional
        reset_to(2);
        cyc(1, 3'd2, 32'd3, 0, 0, 0, 0, 0, 0);
        check("b_pc", pc_out, 32'd5);
        check("b_taken", 32'(branch_taken), 32'd1);
        cyc(1, 3'd1, 0, 0, 32'd69, 0, 0, 0, 0);
        check("br_pc", pc_out, 32'd69);
        cyc(1, 3'd2, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
        check("b_neg_pc", pc_out, 32'd67);
        idle();
        check("taken_pulse", 32'(branch_taken), 32'd0);

        // Conditional
        reset_to(2);
        cyc(1, 3'd4, 0, 32'd3, 0, 0, 0, 0, 0);
        check("bz_nt_pc", pc_out, 32'd3);
        check("bz_nt_taken", 32'(branch_taken), 32'd0);
        cyc(1, 3'd4, 0, 32'd3, 0, 1, 0, 0, 0);
        check("bz_t_pc", pc_out, 32'd6);
        check("bz_t_taken", 32'(branch_taken), 32'd1);
        cyc(1, 3'd6, 0, 32'd3, 0, 0, 1, 0, 0);
        check("bcy_pc", pc_out, 32'd9);

        // Call / return
        reset_to(2);
        cyc(1, 3'd3, 32'd2, 0, 0, 0, 0, 0, 0);
        check("bl_pc", pc_out, 32'd4);
        check("bl_count", 32'(ras_count), 32'd1);
        cyc(1, 3'd7, 0, 0, 0, 0, 0, 0, 0);
        check("ret_pc", pc_out, 32'd3);
        check("ret_count", 32'(ras_count), 32'd0);
        check("ret_taken", 32'(branch_taken), 32'd1);

        // RAS limits: pushes 1,11,21,31,41; 1 is overwritten
        reset_to(0);
        for (int i = 0; i < 5; i++) cyc(1, 3'd3, 32'd10, 0, 0, 0, 0, 0, 0);
        check("ovf_count", 32'(ras_count), 32'd4);
        check("ovf_flag", 32'(ras_ovf), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 3'd7, 0, 0, 0, 0, 0, 0, 0);
            check("ras_ret_pc", pc_out, 32'(41 - 10 * i));
        end
        cyc(1, 3'd7, 0, 0, 0, 0, 0, 0, 0);
        check("udf_pc", pc_out, 32'd12);
        check("udf_flag", 32'(ras_udf), 32'd1);
        check("udf_taken", 32'(branch_taken), 32'd0);
        cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
        check("clr_ovf", 32'(ras_ovf), 32'd0);
        check("clr_udf", 32'(ras_udf), 32'd0);

        // Stall, then wrap-around
        reset_to(2);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd1, 0, 0, 32'd69, 0, 0, 1, 0);
            check("stall_pc", pc_out, 32'd2);
            check("stall_taken", 32'(branch_taken), 32'd0);
        end
        cyc(1, 3'd1, 0, 0, 32'd69, 0, 0, 0, 0);
        check("unstall_pc", pc_out, 32'd69);
        cyc(1, 3'd1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        idle();
        check("wrap_pc", pc_out, 32'd0);

        // Randomized traffic with occasional async reset
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 250) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                32'($urandom_range(0, 64)) - 32'd32,
                32'($urandom_range(0, 64)) - 32'd32,
                ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
